// File: rtl/branch_target_buffer_table.sv
// Direct-mapped branch target buffer: tagged entries holding a target and a
// saturating taken counter, with a registered fetch-side lookup and an execute-side update port.
module branch_target_buffer_table #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input  logic              btb_clk,
  input  logic              btb_rst_n,
  input  logic              btb_lookup_valid,
  input  logic [ADDR_W-1:0] btb_lookup_pc,
  output logic              btb_pred_valid,
  output logic              btb_pred_hit,
  output logic              btb_pred_taken,
  output logic [ADDR_W-1:0] btb_pred_target,
  input  logic              btb_upd_valid,
  input  logic [ADDR_W-1:0] btb_upd_pc,
  input  logic              btb_upd_taken,
  input  logic [ADDR_W-1:0] btb_upd_target,
  input  logic              btb_flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = btb_lookup_pc[IDX_W+1:2];
  assign lk_tag = btb_lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign up_idx = btb_upd_pc[IDX_W+1:2];
  assign up_tag = btb_upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign unused_pc_lsbs = ^{btb_lookup_pc[1:0], btb_upd_pc[1:0]};

  // Lookup reads the table state before this edge's update/flush lands.
  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      btb_pred_valid  <= 1'b0;
      btb_pred_hit    <= 1'b0;
      btb_pred_taken  <= 1'b0;
      btb_pred_target <= '0;
    end else if (btb_lookup_valid) begin
      btb_pred_valid  <= 1'b1;
      btb_pred_hit    <= lk_hit;
      btb_pred_taken  <= lk_hit && ctr_q[lk_idx][CTR_W-1];
      btb_pred_target <= lk_hit ? tgt_q[lk_idx] : '0;
    end else begin
      btb_pred_valid  <= 1'b0;
      btb_pred_hit    <= 1'b0;
      btb_pred_taken  <= 1'b0;
      btb_pred_target <= '0;
    end
  end

  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (btb_flush) begin
      valid_q <= '0;
    end else if (btb_upd_valid) begin
      if (up_hit) begin
        if (btb_upd_taken) begin
          tgt_q[up_idx] <= btb_upd_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (btb_upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= btb_upd_target;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer_table.sv
// Scoreboard bench for branch_target_buffer_table (default parameters: 16 entries,
// 32-bit PCs, 2-bit counters); a behavioural model predicts every lookup result.
module tb_branch_target_buffer_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic        v;
    logic        h;
    logic        t;
    logic [31:0] tgt;
  } pred_t;

  pred_t sb[$];

  logic [15:0] m_valid;
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];

  always #5 clk = ~clk;

  branch_target_buffer_table #(
    .ENTRIES(16),
    .ADDR_W (32),
    .CTR_W  (2)
  ) dut (
    .btb_clk         (clk),
    .btb_rst_n       (rst_n),
    .btb_lookup_valid(lookup_valid),
    .btb_lookup_pc   (lookup_pc),
    .btb_pred_valid  (pred_valid),
    .btb_pred_hit    (pred_hit),
    .btb_pred_taken  (pred_taken),
    .btb_pred_target (pred_target),
    .btb_upd_valid   (upd_valid),
    .btb_upd_pc      (upd_pc),
    .btb_upd_taken   (upd_taken),
    .btb_upd_target  (upd_target),
    .btb_flush       (flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 2'd1;
    end
  endtask

  function automatic pred_t model_lookup(input logic lv, input logic [31:0] pc);
    pred_t p;
    int    ix;
    ix    = int'(pc[5:2]);
    p.v   = lv;
    p.h   = lv && m_valid[ix] && (m_tag[ix] == pc[31:6]);
    p.t   = p.h && (m_ctr[ix] >= 2'd2);
    p.tgt = p.h ? m_tgt[ix] : 32'h0;
    return p;
  endfunction

  task automatic model_update(input logic uv, input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic fl);
    int   ix;
    logic hit;
    ix  = int'(pc[5:2]);
    hit = m_valid[ix] && (m_tag[ix] == pc[31:6]);
    if (fl) begin
      m_valid = '0;
    end else if (uv) begin
      if (hit && tk) begin
        m_tgt[ix] = tgt;
        if (m_ctr[ix] < 2'd3) m_ctr[ix] = m_ctr[ix] + 2'd1;
      end else if (hit) begin
        if (m_ctr[ix] > 2'd0) m_ctr[ix] = m_ctr[ix] - 2'd1;
      end else if (tk) begin
        m_valid[ix] = 1'b1;
        m_tag[ix]   = pc[31:6];
        m_tgt[ix]   = tgt;
        m_ctr[ix]   = 2'd2;
      end
    end
  endtask

  task automatic pop_and_check();
    pred_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("pred_valid", 64'(pred_valid), 64'(e.v));
      check("pred_hit", 64'(pred_hit), 64'(e.h));
      check("pred_taken", 64'(pred_taken), 64'(e.t));
      check("pred_target", 64'(pred_target), 64'(e.tgt));
    end
  endtask

  // One clock: drive, push the expected prediction, apply the model update at the edge, compare.
  task automatic cycle(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic fl);
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    flush        = fl;
    sb.push_back(model_lookup(lv, lpc));
    @(posedge clk);
    model_update(uv, upc, ut, utgt, fl);
    #1;
    pop_and_check();
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    cycle(1'b0, 32'h0, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h0000_1040; pcs[1] = 32'h0000_1440; pcs[2] = 32'h0000_1840;
    pcs[3] = 32'h0000_2008; pcs[4] = 32'h0000_3000; pcs[5] = 32'h0000_1043;

    rst_n = 1'b1;
    lookup_valid = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0;
    upd_taken = 0; upd_target = '0; flush = 0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred_valid", 64'(pred_valid), 64'd0);
    check("reset_pred_hit", 64'(pred_hit), 64'd0);
    check("reset_pred_taken", 64'(pred_taken), 64'd0);
    check("reset_pred_target", 64'(pred_target), 64'd0);
    rst_n = 1'b1;

    // Cold lookup, allocate, hit.
    look(32'h0000_1040);
    upd(32'h0000_1040, 1'b1, 32'h0000_2000);
    look(32'h0000_1040);
    check("alloc_taken_direct", 64'(pred_taken), 64'd1);

    // Saturating training.
    repeat (4) begin
      upd(32'h0000_1040, 1'b1, 32'h0000_2100);
      look(32'h0000_1040);
    end
    repeat (3) begin
      upd(32'h0000_1040, 1'b0, 32'h0000_9999);
      look(32'h0000_1040);
    end
    check("ctr0_hit_direct", 64'(pred_hit), 64'd1);
    check("ctr0_taken_direct", 64'(pred_taken), 64'd0);
    upd(32'h0000_1040, 1'b1, 32'h0000_2200);
    look(32'h0000_1040);
    check("ctr1_taken_direct", 64'(pred_taken), 64'd0);

    // Aliasing and eviction.
    upd(32'h0000_1440, 1'b1, 32'h0000_3440);
    look(32'h0000_1040);
    look(32'h0000_1440);
    upd(32'h0000_1840, 1'b0, 32'h0000_5555);
    look(32'h0000_1440);
    check("alias_target_direct", 64'(pred_target), 64'h3440);

    // Same-cycle collision: lookup sees the pre-update counter.
    upd(32'h0000_1040, 1'b1, 32'h0000_2000);
    cycle(1'b1, 32'h0000_1040, 1'b1, 32'h0000_1040, 1'b0, 32'h0, 1'b0);
    check("collision_taken_direct", 64'(pred_taken), 64'd1);
    look(32'h0000_1040);
    check("after_collision_taken_direct", 64'(pred_taken), 64'd0);
    cycle(1'b1, 32'h0000_1040, 1'b1, 32'h0000_2008, 1'b1, 32'h0000_5000, 1'b0);
    look(32'h0000_2008);

    // Flush wins over a concurrent update; lookup in that cycle sees pre-flush state.
    cycle(1'b1, 32'h0000_1040, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_7000, 1'b1);
    check("flush_cycle_hit_direct", 64'(pred_hit), 64'd1);
    look(32'h0000_3000);
    check("flush_drop_hit_direct", 64'(pred_hit), 64'd0);
    look(32'h0000_1040);
    look(32'h0000_2008);

    // Randomised traffic over a small aliasing PC set.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 5)],
            1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
            1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset between edges while a prediction is being presented.
    upd(32'h0000_1040, 1'b1, 32'h0000_2000);
    look(32'h0000_1040);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0000_1040;
    upd_valid    = 1'b0;
    flush        = 1'b0;
    sb.push_back(model_lookup(1'b1, 32'h0000_1040));
    @(posedge clk);
    #1;
    pop_and_check();
    lookup_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pred_valid", 64'(pred_valid), 64'd0);
    check("async_rst_pred_hit", 64'(pred_hit), 64'd0);
    check("async_rst_pred_taken", 64'(pred_taken), 64'd0);
    check("async_rst_pred_target", 64'(pred_target), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h0000_1040);
    upd(32'h0000_1040, 1'b1, 32'h0000_4000);
    look(32'h0000_1040);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
